// File: rtl/bus_bridge_pkg.sv
// Shared definitions for the CPU-to-device bus bridge: FSM state encodings,
// default device window bases and the CP0 interrupt vector width.
package bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int          TIMEOUT_DEFAULT   = 16;
    localparam logic [31:0] DEV0_BASE_DEFAULT = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE_DEFAULT = 32'h0000_7F10;
    localparam int          CP0_DEV_CNT       = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/bus_bridge.sv
// Bridges single CPU bus requests onto two 16-byte device windows with an
// acknowledge timeout, a sticky bus-error flag and synchronized device IRQs.
//
//   state  | meaning
//   IDLE   | waiting for a CPU request; decodes the address when one arrives
//   ACCESS | device selected, waiting for its acknowledge or the timeout
//   DONE   | result captured, DevSel dropped; PrReady follows on the next cycle
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int          TIMEOUT   = TIMEOUT_DEFAULT,
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEFAULT,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   PrReq,
    input  logic [31:0]            PrAddr,
    input  logic [31:0]            PrWD,
    input  logic                   PrWe,
    output logic [31:0]            PrRD,
    output logic                   PrReady,
    output logic [1:0]             DevSel,
    output logic [1:0]             DevAddr,
    output logic [31:0]            DevWD,
    output logic                   DevWe,
    input  logic [31:0]            DevRD0,
    input  logic [31:0]            DevRD1,
    input  logic [1:0]             DevAck,
    input  logic [1:0]             DevIRQ,
    input  logic                   ErrClr,
    output logic                   BusErr,
    output logic [CP0_DEV_CNT-1:0] HWInt
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic              we_q, we_d;
    logic [31:0]       rd_q, rd_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              dev0_hit, dev1_hit, req_take, ack_hit, tmo_hit, err_set;
    logic [1:0]        irq_sync;
    logic              unused_addr_lsb;

    assign dev0_hit        = PrAddr[31:4] == DEV0_BASE[31:4];
    assign dev1_hit        = PrAddr[31:4] == DEV1_BASE[31:4];
    // PrReq is still held while PrReady is high; do not start a second access from it
    assign req_take        = PrReq && !ready_q;
    assign ack_hit         = |(DevAck & sel_q);
    assign tmo_hit         = cnt_q == CNT_LAST;
    assign unused_addr_lsb = ^PrAddr[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_take) begin
                    state_d = (dev0_hit || dev1_hit) ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                if (ack_hit || tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d   = sel_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        we_d    = we_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        ready_d = state_q == ST_DONE;
        case (state_q)
            ST_IDLE: begin
                if (req_take) begin
                    if (dev0_hit || dev1_hit) begin
                        sel_d  = dev0_hit ? 2'b01 : 2'b10;
                        addr_d = PrAddr[3:2];
                        wd_d   = PrWD;
                        we_d   = PrWe;
                        cnt_d  = '0;
                    end else begin
                        rd_d    = '0;
                        err_set = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // an acknowledge on the final timeout cycle still completes normally
                if (ack_hit) begin
                    rd_d  = we_q ? '0 : (sel_q[0] ? DevRD0 : DevRD1);
                    sel_d = '0;
                    we_d  = 1'b0;
                end else if (tmo_hit) begin
                    rd_d    = '0;
                    err_set = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                sel_d = '0;
                we_d  = 1'b0;
            end
            default: begin
                sel_d = '0;
                we_d  = 1'b0;
            end
        endcase
        err_d = err_set ? 1'b1 : (ErrClr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_irq_sync
        sync2 u_sync2 (
            .clk (clk),
            .rst (rst),
            .d_i (DevIRQ[i]),
            .q_o (irq_sync[i])
        );
    end

    always_comb begin
        HWInt    = '0;
        HWInt[1] = irq_sync[0];
        HWInt[2] = irq_sync[1];
        HWInt[3] = err_q;
    end

    assign PrRD    = rd_q;
    assign PrReady = ready_q;
    assign DevSel  = sel_q;
    assign DevAddr = addr_q;
    assign DevWD   = wd_q;
    assign DevWe   = we_q;
    assign BusErr  = err_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed scenarios with literal
// expectations followed by randomized transactions against a cycle-indexed model.
module tb_bus_bridge;
    import bus_bridge_pkg::*;

    localparam int          TO    = 16;
    localparam logic [31:0] BASE0 = 32'h0000_7F00;
    localparam logic [31:0] BASE1 = 32'h0000_7F10;
    localparam int          NCYC  = 16384;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   PrReq = 1'b0;
    logic [31:0]            PrAddr = '0;
    logic [31:0]            PrWD = '0;
    logic                   PrWe = 1'b0;
    logic [31:0]            PrRD;
    logic                   PrReady;
    logic [1:0]             DevSel;
    logic [1:0]             DevAddr;
    logic [31:0]            DevWD;
    logic                   DevWe;
    logic [31:0]            DevRD0 = '0;
    logic [31:0]            DevRD1 = '0;
    logic [1:0]             DevAck = '0;
    logic [1:0]             DevIRQ = '0;
    logic                   ErrClr = 1'b0;
    logic                   BusErr;
    logic [CP0_DEV_CNT-1:0] HWInt;

    bus_bridge #(.TIMEOUT(TO), .DEV0_BASE(BASE0), .DEV1_BASE(BASE1)) dut (
        .clk(clk), .rst(rst), .PrReq(PrReq), .PrAddr(PrAddr), .PrWD(PrWD), .PrWe(PrWe),
        .PrRD(PrRD), .PrReady(PrReady), .DevSel(DevSel), .DevAddr(DevAddr), .DevWD(DevWD),
        .DevWe(DevWe), .DevRD0(DevRD0), .DevRD1(DevRD1), .DevAck(DevAck), .DevIRQ(DevIRQ),
        .ErrClr(ErrClr), .BusErr(BusErr), .HWInt(HWInt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Expected outputs indexed by the number of the rising edge they follow.
    logic [1:0]  exp_sel   [NCYC];
    logic        exp_we    [NCYC];
    logic [1:0]  exp_addr  [NCYC];
    logic [31:0] exp_wd    [NCYC];
    logic        exp_ready [NCYC];
    logic        ev_rd_v   [NCYC];
    logic [31:0] ev_rd     [NCYC];
    logic        ev_err    [NCYC];

    logic [31:0] m_rd;
    logic        m_err;
    logic [1:0]  m_s1, m_s2;

    int   errclr_mode = 0;
    logic clr_on_req  = 1'b0;
    logic irq_rand    = 1'b0;
    logic noise_all   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
    endtask

    // Compare process: update the model on each rising edge, check on the falling edge.
    initial begin
        logic [CP0_DEV_CNT-1:0] hw_exp;
        for (int i = 0; i < NCYC; i++) begin
            exp_sel[i] = '0; exp_we[i] = 1'b0; exp_addr[i] = '0; exp_wd[i] = '0;
            exp_ready[i] = 1'b0; ev_rd_v[i] = 1'b0; ev_rd[i] = '0; ev_err[i] = 1'b0;
        end
        m_rd = '0; m_err = 1'b0; m_s1 = '0; m_s2 = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_rd = '0; m_err = 1'b0; m_s1 = '0; m_s2 = '0;
            end else begin
                if (ev_rd_v[cyc]) m_rd = ev_rd[cyc];
                if (ev_err[cyc]) m_err = 1'b1;
                else if (ErrClr) m_err = 1'b0;
                m_s2 = m_s1;
                m_s1 = DevIRQ;
            end
            @(negedge clk);
            if (!rst) begin
                chk("rst_outputs", {PrRD, 28'd0, PrReady, DevWe, BusErr, 1'b0} , 64'd0);
                chk("rst_dev", {DevWD, DevSel, DevAddr, HWInt}, '0);
            end else if (cyc < NCYC) begin
                hw_exp    = '0;
                hw_exp[1] = m_s2[0];
                hw_exp[2] = m_s2[1];
                hw_exp[3] = m_err;
                chk("DevSel", DevSel, exp_sel[cyc]);
                chk("PrReady", PrReady, exp_ready[cyc]);
                chk("DevWe", DevWe, exp_we[cyc]);
                chk("PrRD", PrRD, m_rd);
                chk("BusErr", BusErr, m_err);
                chk("HWInt", HWInt, hw_exp);
                if (exp_sel[cyc] != 2'b00) begin
                    chk("DevAddr", DevAddr, exp_addr[cyc]);
                    chk("DevWD", DevWD, exp_wd[cyc]);
                end
            end
        end
    end

    task automatic drive_misc();
        case (errclr_mode)
            0:       ErrClr = 1'b0;
            1:       ErrClr = 1'b1;
            default: ErrClr = ($urandom_range(0, 7) == 0);
        endcase
        if (irq_rand && $urandom_range(0, 7) == 0) DevIRQ[$urandom_range(0, 1)] ^= 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_misc();
            PrReq  = 1'b0;
            DevAck = '0;
        end
    endtask

    // One CPU transaction; k is the ACCESS cycle carrying the acknowledge (0 = never).
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                          input int k, input logic force_rd, input logic [31:0] rd_fix,
                          output int ready_off, output logic [1:0] sel_seen,
                          output logic [1:0] addr_seen, output logic [31:0] wd_seen,
                          output logic we_seen);
        int         e0, n;
        logic [1:0] sel;
        logic       acked;
        if (addr[31:4] == BASE0[31:4])      sel = 2'b01;
        else if (addr[31:4] == BASE1[31:4]) sel = 2'b10;
        else                                sel = 2'b00;
        @(negedge clk);
        drive_misc();
        ErrClr = ErrClr | clr_on_req;
        DevAck = '0;
        PrReq  = 1'b1;
        PrAddr = addr;
        PrWD   = wd;
        PrWe   = we;
        e0     = cyc + 1;
        acked  = (sel != 2'b00) && (k >= 1) && (k <= TO);
        if (sel != 2'b00) begin
            n = acked ? k : TO;
            for (int i = 0; i < n; i++) begin
                exp_sel[e0+i]  = sel;
                exp_we[e0+i]   = we;
                exp_addr[e0+i] = addr[3:2];
                exp_wd[e0+i]   = wd;
            end
        end else begin
            n = 0;
        end
        ev_rd_v[e0+n]     = 1'b1;
        ev_rd[e0+n]       = '0;
        ev_err[e0+n]      = !acked;
        exp_ready[e0+n+1] = 1'b1;
        ready_off = -1;
        sel_seen  = '0;
        addr_seen = '0;
        wd_seen   = '0;
        we_seen   = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            sel_seen |= DevSel;
            if (j == 1) begin
                addr_seen = DevAddr;
                wd_seen   = DevWD;
                we_seen   = DevWe;
            end
            if (PrReady) begin
                ready_off = cyc - e0;
                break;
            end
            drive_misc();
            DevRD0 = $urandom;
            DevRD1 = $urandom;
            if (force_rd) begin
                if (sel == 2'b10) DevRD1 = rd_fix;
                else              DevRD0 = rd_fix;
            end
            DevAck = noise_all ? 2'b11 : 2'($urandom_range(0, 3));
            if (sel == 2'b01)      DevAck[0] = (j == k);
            else if (sel == 2'b10) DevAck[1] = (j == k);
            if (acked && j == k && !we) ev_rd[e0+n] = (sel == 2'b01) ? DevRD0 : DevRD1;
        end
        chk("ready_seen", 32'(ready_off >= 0), 32'd1);
        PrReq  = 1'b0;
        DevAck = '0;
    endtask

    task automatic clear_err();
        @(negedge clk);
        ErrClr = 1'b1;
        @(negedge clk);
        ErrClr = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          off, e0;
        logic [1:0]  sseen, aseen;
        logic [31:0] wseen, addr;
        logic        weseen;
        int          k, kind;

        repeat (3) @(negedge clk);
        chk("reset_PrRD", PrRD, 32'd0);
        chk("reset_PrReady", PrReady, 32'd0);
        chk("reset_DevSel", DevSel, 32'd0);
        chk("reset_BusErr", BusErr, 32'd0);
        chk("reset_HWInt", HWInt, 32'd0);
        #2 rst = 1'b1;

        // Mapped read, device 0, acknowledged in the first ACCESS cycle
        do_txn(32'h0000_7F04, 1'b0, 32'h0, 1, 1'b1, 32'hDEADBEEF, off, sseen, aseen, wseen, weseen);
        chk("rd0_latency", off, 32'd2);
        chk("rd0_sel", sseen, 32'b01);
        chk("rd0_addr", aseen, 32'd1);
        chk("rd0_data", PrRD, 32'hDEADBEEF);
        chk("rd0_buserr", BusErr, 32'd0);
        idle(2);

        // Write to device 1 with the acknowledge after three silent ACCESS cycles
        do_txn(32'h0000_7F18, 1'b1, 32'h12345678, 4, 1'b0, 32'h0, off, sseen, aseen, wseen, weseen);
        chk("wr1_latency", off, 32'd5);
        chk("wr1_sel", sseen, 32'b10);
        chk("wr1_we", weseen, 32'd1);
        chk("wr1_wd", wseen, 32'h12345678);
        chk("wr1_addr", aseen, 32'd2);
        chk("wr1_prrd", PrRD, 32'd0);
        idle(2);

        // Timeout
        do_txn(32'h0000_7F00, 1'b0, 32'h0, 0, 1'b0, 32'h0, off, sseen, aseen, wseen, weseen);
        chk("tmo_latency", off, 32'(TO + 1));
        chk("tmo_prrd", PrRD, 32'd0);
        chk("tmo_buserr", BusErr, 32'd1);
        chk("tmo_hwint3", HWInt[3], 32'd1);
        clear_err();
        chk("clr_buserr", BusErr, 32'd0);
        chk("clr_hwint3", HWInt[3], 32'd0);

        // Unmapped requests; the second carries ErrClr in its sampling cycle
        do_txn(32'h0000_1000, 1'b0, 32'h0, 1, 1'b0, 32'h0, off, sseen, aseen, wseen, weseen);
        chk("unm_latency", off, 32'd1);
        chk("unm_sel", sseen, 32'd0);
        chk("unm_buserr", BusErr, 32'd1);
        clr_on_req = 1'b1;
        do_txn(32'h0000_2000, 1'b1, 32'h5, 1, 1'b0, 32'h0, off, sseen, aseen, wseen, weseen);
        clr_on_req = 1'b0;
        chk("unm2_set_wins", BusErr, 32'd1);
        clear_err();

        // Acknowledge exactly on the timeout cycle, and one cycle too late
        do_txn(32'h0000_7F1C, 1'b0, 32'h0, TO, 1'b1, 32'hCAFE0001, off, sseen, aseen, wseen, weseen);
        chk("ack_at_tmo_latency", off, 32'(TO + 1));
        chk("ack_at_tmo_buserr", BusErr, 32'd0);
        chk("ack_at_tmo_data", PrRD, 32'hCAFE0001);
        do_txn(32'h0000_7F08, 1'b0, 32'h0, TO + 1, 1'b0, 32'h0, off, sseen, aseen, wseen, weseen);
        chk("ack_late_latency", off, 32'(TO + 1));
        chk("ack_late_buserr", BusErr, 32'd1);
        clear_err();

        // IRQ synchronizer latency
        @(negedge clk);
        DevIRQ[1] = 1'b1;
        @(negedge clk);
        chk("irq_1edge", HWInt[2], 32'd0);
        @(negedge clk);
        chk("irq_2edge", HWInt[2], 32'd1);
        DevIRQ = '0;

        // Foreign acknowledge held high while device 0 is selected
        noise_all = 1'b1;
        do_txn(32'h0000_7F0C, 1'b0, 32'h0, 3, 1'b1, 32'h0BADF00D, off, sseen, aseen, wseen, weseen);
        noise_all = 1'b0;
        chk("foreign_ack_latency", off, 32'd4);
        chk("foreign_ack_data", PrRD, 32'h0BADF00D);
        idle(3);

        // Reset in the middle of an access
        @(negedge clk);
        PrReq  = 1'b1;
        PrAddr = 32'h0000_7F00;
        PrWe   = 1'b0;
        e0     = cyc + 1;
        for (int i = 0; i < 3; i++) exp_sel[e0+i] = 2'b01;
        repeat (3) @(negedge clk);
        chk("pre_rst_sel", DevSel, 32'b01);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sel", DevSel, 32'd0);
        chk("async_rst_ready", PrReady, 32'd0);
        chk("async_rst_prrd", PrRD, 32'd0);
        PrReq  = 1'b0;
        DevAck = 2'b01;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        off = 0;
        repeat (4) begin
            @(negedge clk);
            off += 32'(PrReady) + 32'(DevSel != 2'b00);
        end
        chk("post_rst_quiet", off, 32'd0);
        DevAck = '0;
        idle(2);

        // Randomized traffic
        errclr_mode = 2;
        irq_rand    = 1'b1;
        repeat (150) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1:    addr = BASE0 | 32'($urandom_range(0, 15));
                2:       addr = BASE1 | 32'($urandom_range(0, 15));
                default: begin
                    addr = $urandom;
                    if (addr[31:4] == BASE0[31:4] || addr[31:4] == BASE1[31:4]) addr[31] = 1'b1;
                end
            endcase
            case ($urandom_range(0, 7))
                0:       k = 1;
                1:       k = 2;
                2:       k = 3;
                3:       k = $urandom_range(4, TO - 2);
                4:       k = TO - 1;
                5:       k = TO;
                6:       k = TO + 1;
                default: k = 0;
            endcase
            do_txn(addr, 1'($urandom_range(0, 1)), $urandom, k, 1'b0, 32'h0,
                   off, sseen, aseen, wseen, weseen);
            idle($urandom_range(0, 2));
        end
        errclr_mode = 0;
        irq_rand    = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
